// File: rtl/lut_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lut_pkg
// Description : Shared types, defaults and canned truth tables for the
//               programmable LUT cell.
// Revision    : 1.0 - initial release
// ============================================================================
package lut_pkg;

    // Configuration state of a LUT site
    typedef enum logic [1:0] {
        UNCONF  = 2'd0,
        LOADING = 2'd1,
        READY   = 2'd2
    } lut_state_e;

    localparam int K_DEFAULT = 2;

    // Truth-table depth for a K-input cell
    function automatic int depth(input int k);
        return 1 << k;
    endfunction

    // Canned K=2 truth tables; bit i is the output for sel == i
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_AND  = 4'b1000;

endpackage
`default_nettype wire

// File: rtl/lut_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : lut_cfg_loader
// Description : Holds the LUT truth table. Accepts a serial (MSB first) or a
//               parallel load, tracks configuration state and pulses
//               o_cfg_done for one cycle when a load completes.
// Revision    : 1.0 - initial release
// ============================================================================
module lut_cfg_loader
    import lut_pkg::*;
#(
    parameter int                   K           = K_DEFAULT,
    parameter logic [depth(K)-1:0]  RESET_TABLE = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_cfg_en,
    input  logic                    i_cfg_bit,
    input  logic                    i_cfg_load,
    input  logic [depth(K)-1:0]     i_cfg_word,
    output logic [depth(K)-1:0]     o_table,
    output logic                    o_ready,
    output logic                    o_cfg_done
);

    localparam int N  = depth(K);
    localparam int CW = $clog2(N + 1);

    lut_state_e     r_state;
    lut_state_e     w_state_nxt;
    logic [N-1:0]   r_table;
    logic [N-1:0]   w_table_nxt;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_nxt;
    logic           r_cfg_done;
    logic           w_cfg_done_nxt;

    // State register: configuration state, table, bit counter and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= UNCONF;
            r_table    <= RESET_TABLE;
            r_cnt      <= '0;
            r_cfg_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_table    <= w_table_nxt;
            r_cnt      <= w_cnt_nxt;
            r_cfg_done <= w_cfg_done_nxt;
        end
    end

    // Next-state logic: parallel load dominates and aborts any serial load
    always_comb begin
        w_state_nxt    = r_state;
        w_table_nxt    = r_table;
        w_cnt_nxt      = r_cnt;
        w_cfg_done_nxt = 1'b0;
        if (i_cfg_load) begin
            w_table_nxt    = i_cfg_word;
            w_cnt_nxt      = '0;
            w_state_nxt    = READY;
            w_cfg_done_nxt = 1'b1;
        end else if (i_cfg_en) begin
            w_table_nxt = {r_table[N-2:0], i_cfg_bit};
            if (r_state != LOADING) begin
                // First bit of a fresh serial load
                w_state_nxt = LOADING;
                w_cnt_nxt   = CW'(1);
            end else if (r_cnt == CW'(N - 1)) begin
                // N-th bit just shifted in: table complete
                w_state_nxt    = READY;
                w_cnt_nxt      = '0;
                w_cfg_done_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + CW'(1);
            end
        end
    end

    // Output logic: expose table, readiness and the done pulse
    always_comb begin
        o_table    = r_table;
        o_ready    = (r_state == READY);
        o_cfg_done = r_cfg_done;
    end

endmodule
`default_nettype wire

// File: rtl/prog_lut_cell.sv
`default_nettype none
// ============================================================================
// Module      : prog_lut_cell
// Description : Run-time programmable K-input lookup-table cell. The table is
//               configured through lut_cfg_loader; evaluation reads
//               table[sel] with one cycle of latency and a valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_lut_cell
    import lut_pkg::*;
#(
    parameter int                   K           = K_DEFAULT,  // legal 1..6
    parameter logic [depth(K)-1:0]  RESET_TABLE = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_en,
    input  logic                    cfg_bit,
    input  logic                    cfg_load,
    input  logic [depth(K)-1:0]     cfg_word,
    input  logic                    in_valid,
    input  logic [K-1:0]            sel,
    output logic                    out,
    output logic                    out_valid,
    output logic                    ready,
    output logic                    cfg_done
);

    localparam int N = depth(K);

    logic [N-1:0]   w_table;
    logic           w_ready;
    logic           r_out;
    logic           r_out_valid;

    lut_cfg_loader #(
        .K           (K),
        .RESET_TABLE (RESET_TABLE)
    ) u_loader (
        .clk        (clk),
        .rst        (reset),
        .i_cfg_en   (cfg_en),
        .i_cfg_bit  (cfg_bit),
        .i_cfg_load (cfg_load),
        .i_cfg_word (cfg_word),
        .o_table    (w_table),
        .o_ready    (w_ready),
        .o_cfg_done (cfg_done)
    );

    // Evaluation register: uses the table as it stood before this edge, so a
    // same-cycle load only becomes visible to the next request
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (in_valid && w_ready) begin
            r_out       <= w_table[sel];
            r_out_valid <= 1'b1;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    // Drive the outward-facing result and status
    always_comb begin
        out       = r_out;
        out_valid = r_out_valid;
        ready     = w_ready;
    end

endmodule
`default_nettype wire
